// File: rtl/streaming_deskewer_pkg.sv
// streaming_deskewer_pkg: shared defaults and helpers for the deskewer slice.
// Array size and lane width default from the project-wide macros when present.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package streaming_deskewer_pkg;
    localparam int DEF_N     = `ARRAY_SIZE;
    localparam int DEF_DW    = `DATA_WIDTH;
    localparam int DEF_DEPTH = 8;

    function automatic int ptr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/streaming_deskewer_if.sv
// streaming_deskewer_if: skewed input / aligned output stream bundle.
// in_valid/in_ready/data_in: skewed beat admission (lane i lags lane 0 by i cycles)
// out_valid/out_ready/data_out: aligned vector toward writeback; level: buffer occupancy
interface streaming_deskewer_if
    import streaming_deskewer_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int DATA_WIDTH = DEF_DW,
    parameter int FIFO_DEPTH = DEF_DEPTH
) ();
    logic                               in_valid;
    logic                               in_ready;
    logic [DATA_WIDTH-1:0]              data_in [N];
    logic                               out_valid;
    logic                               out_ready;
    logic [DATA_WIDTH-1:0]              data_out [N];
    logic [$clog2(FIFO_DEPTH+1)-1:0]    level;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, level
    );
    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, level
    );
endinterface

// File: rtl/streaming_deskewer_sync_fifo.sv
// sync_fifo: counter-tracked circular buffer, any depth >= 2.
// push/wdata: write; pop/rdata: read head (zero when empty); empty/full/count: status
module sync_fifo
    import streaming_deskewer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = ptr_w(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign empty  = count == '0;
    assign full   = count == LW'(DEPTH);
    // Gating keeps the head at zero out of reset without clearing storage.
    assign rdata  = empty ? '0 : mem[rp];

    always_ff @(posedge clk)
        if (push) mem[wp] <= wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= (wp == PW'(DEPTH-1)) ? '0 : wp + PW'(1);
            if (do_pop) rp <= (rp == PW'(DEPTH-1)) ? '0 : rp + PW'(1);
            count <= count + LW'(push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/streaming_deskewer.sv
// streaming_deskewer: realigns skewed systolic drain lanes into whole vectors.
// clk/rst_n: clock, synchronous active-low reset; bus: slave side of streaming_deskewer_if
module streaming_deskewer
    import streaming_deskewer_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int DATA_WIDTH = DEF_DW,
    parameter int FIFO_DEPTH = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    streaming_deskewer_if.slave  bus
);
    localparam int LW = $clog2(FIFO_DEPTH+1);

    logic                      accept, push, pop, empty, full;
    logic [N*DATA_WIDTH-1:0]   wdata, rdata;
    logic [LW-1:0]             count;
    int                        reserved;

    assign accept        = bus.in_valid && bus.in_ready;
    // Every in-flight beat holds a slot, so a drain that cannot stall never overflows.
    assign bus.in_ready  = (int'(count) + reserved) < FIFO_DEPTH;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_valid = !empty;
    assign bus.level     = count;

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == N-1) begin : g_pass
            assign wdata[i*DATA_WIDTH +: DATA_WIDTH] = bus.data_in[i];
        end else begin : g_dl
            logic [DATA_WIDTH-1:0] dl [N-1-i];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < N-1-i; k++) dl[k] <= '0;
                end else begin
                    dl[0] <= bus.data_in[i];
                    for (int k = 1; k < N-1-i; k++) dl[k] <= dl[k-1];
                end
            end
            assign wdata[i*DATA_WIDTH +: DATA_WIDTH] = dl[N-2-i];
        end
        assign bus.data_out[i] = rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    if (N > 1) begin : g_vsr
        logic [N-2:0] sr;
        always_ff @(posedge clk) begin
            if (!rst_n) sr <= '0;
            else sr <= (N-1)'({sr, accept});
        end
        assign push     = sr[N-2];
        assign reserved = $countones(sr);
    end else begin : g_novsr
        assign push     = accept;
        assign reserved = 0;
    end

    sync_fifo #(.WIDTH(N*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .wdata(wdata), .rdata(rdata), .empty(empty), .full(full), .count(count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: tb/tb_streaming_deskewer.sv
// tb_streaming_deskewer: scoreboard bench with a cycle model of level/in_ready.
module tb_streaming_deskewer;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 8;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    streaming_deskewer_if #(.N(N), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) bus ();
    streaming_deskewer #(.N(N), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [N*DW-1:0] sb [$];
    logic [N*DW-1:0] hist_d [N];
    bit              hist_v [N];
    int              m_level, k, vectors, errs, acc_cnt;
    bit              seen_ee;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] out_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = bus.data_out[i];
        return v;
    endfunction

    task automatic clear_model();
        sb.delete();
        for (int a = 0; a < N; a++) begin
            hist_v[a] = 0;
            hist_d[a] = '0;
        end
        m_level = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        bus.in_valid = 0;
        bus.out_ready = 0;
        for (int i = 0; i < N; i++) bus.data_in[i] = 8'($urandom);
        @(posedge clk);
        #1;
        rst_n = 1;
        clear_model();
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_data_out", out_vec(), 0);
    endtask

    // One clock: drive, compare against model, advance model.
    task automatic tick(input bit v, input bit ordy);
        logic [N*DW-1:0] nb, exp;
        int resv;
        bit rdy, acc, pop, push;
        for (int i = 0; i < N; i++) nb[i*DW +: DW] = 8'(16*k + i);
        resv = 0;
        for (int a = 1; a < N; a++) resv += int'(hist_v[a]);
        rdy = (m_level + resv) < D;
        acc = v && rdy;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        bus.data_in[0] = acc ? nb[DW-1:0] : (v ? 8'hEE : 8'($urandom));
        for (int i = 1; i < N; i++)
            bus.data_in[i] = hist_v[i] ? hist_d[i][i*DW +: DW] : 8'($urandom);
        #1;
        chk("in_ready", bus.in_ready, rdy);
        chk("level", bus.level, m_level);
        chk("out_valid", bus.out_valid, m_level > 0);
        if (bus.out_valid && bus.data_out[0] == 8'hEE) seen_ee = 1;
        pop = ordy && m_level > 0;
        if (pop) begin
            if (sb.size() == 0) chk("sb_empty_pop", 1, 0);
            else begin
                exp = sb.pop_front();
                chk("data_out", out_vec(), exp);
            end
        end
        push = hist_v[N-1];
        if (acc) begin
            sb.push_back(nb);
            k++;
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        for (int a = N-1; a > 1; a--) begin
            hist_v[a] = hist_v[a-1];
            hist_d[a] = hist_d[a-1];
        end
        hist_v[1] = acc;
        hist_d[1] = nb;
        m_level = m_level + int'(push) - int'(pop);
    endtask

    initial begin
        vectors = 0; errs = 0; k = 0; acc_cnt = 0; seen_ee = 0;
        do_reset();

        // single beat, held until late pop
        tick(1, 0);
        for (int c = 0; c < 6; c++) tick(0, 0);
        chk("single_level", bus.level, 1);
        tick(0, 1);
        chk("single_sb", sb.size(), 0);

        // back-to-back stream
        for (int c = 0; c < 16; c++) tick(1, 1);
        for (int c = 0; c < 6; c++) tick(0, 1);
        chk("stream_sb", sb.size(), 0);

        // backpressure, refused beats carry 0xEE
        acc_cnt = 0;
        for (int c = 0; c < 14; c++) tick(1, 0);
        chk("bp_accepts", acc_cnt, 8);
        chk("bp_level", bus.level, 8);
        for (int c = 0; c < 4; c++) tick(1, 1);
        for (int c = 0; c < 14; c++) tick(0, 1);
        chk("bp_sb", sb.size(), 0);

        // random traffic
        for (int c = 0; c < 80; c++) tick(1'($urandom), 1'($urandom_range(0, 3) != 0));
        for (int c = 0; c < 14; c++) tick(0, 1);
        chk("rand_sb", sb.size(), 0);

        // reset with 3 in flight and 5 buffered
        for (int c = 0; c < 8; c++) tick(1, 0);
        chk("pre_rst_level", bus.level, 5);
        do_reset();
        tick(1, 1);
        for (int c = 0; c < 6; c++) tick(0, 1);
        chk("post_rst_sb", sb.size(), 0);

        chk("no_ee", seen_ee, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
